spi_cfg_rx: RTL and testbench

Write-only SPI configuration receiver sitting directly behind the `spi_nss`/`spi_mosi`/`spi_clk` input pads, inside `synth_top`. It oversamples the SPI pins in the system clock domain and decodes address/data frames. It writes an internal bank of 8-bit configuration registers, which drive the synthesis core that produces `data`. There is no MISO path, so the bus is write-only.

---
 rtl/cd101_pkg.sv | 23 ++
 rtl/spi_cfg_rx_sync_ff.sv | 26 ++
 rtl/spi_cfg_rx.sv | 147 ++++++++++++++
 tb/tb_spi_cfg_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cd101_pkg.sv
// Shared definitions for the configuration path of synth_top.
// - CFG_ADDR_W / CFG_DATA_W: width of an SPI configuration address and data byte.
// - rx_state_t: frame-receiver FSM state (IDLE/ADDR/DATA/HOLD).
// - REG_*: named register addresses consumed by the synthesis core.
package cd101_pkg;

  localparam int CFG_ADDR_W = 8;
  localparam int CFG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

  localparam logic [CFG_ADDR_W-1:0] REG_CTRL    = 8'h00;
  localparam logic [CFG_ADDR_W-1:0] REG_WAVE    = 8'h01;
  localparam logic [CFG_ADDR_W-1:0] REG_FREQ_LO = 8'h02;
  localparam logic [CFG_ADDR_W-1:0] REG_FREQ_HI = 8'h03;
  localparam logic [CFG_ADDR_W-1:0] REG_LEVEL   = 8'h04;

endpackage

// File: rtl/spi_cfg_rx_sync_ff.sv
// sync_ff: single-bit multi-stage synchronizer into the clk domain.
// Ports: clk, rst (async, active-high), d (asynchronous input), q (synchronized).
// Parameters: STAGES (>=2), RST_VAL (value held by every stage during reset).
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_cfg_rx.sv
// spi_cfg_rx: write-only SPI (mode 0) configuration receiver. Oversamples the
// SPI pads in the clk domain, decodes {address, data} frames (MSB first) and
// writes a bank of 8-bit configuration registers.
// Ports:
//   clk, rst            system clock, async active-high reset
//   spi_clk/mosi/nss    raw SPI pads (nss active-low)
//   regs                flattened register bank, reg i at [8i+7:8i]
//   wr_stb              one-cycle pulse per committed write
//   wr_addr/wr_data     address/data of the last write attempt
//   addr_err            one-cycle pulse when a write targets addr >= NUM_REGS
//   dbg_state           current FSM state (rx_state_t encoding)
// Optional feature: define SPI_CFG_BURST_EN to keep writing successive bytes
// to auto-incremented addresses within one frame.
//
// Handshake: there is no back-pressure. A write is a single-cycle event:
// wr_stb (or addr_err) is high for exactly one clk cycle, and wr_addr/wr_data
// are valid from that cycle until the next write attempt.
module spi_cfg_rx
  import cd101_pkg::*;
#(
  parameter int                    NUM_REGS    = 16,
  parameter logic [CFG_DATA_W-1:0] REG_RESET   = 8'h00,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_nss,
  output logic [NUM_REGS*8-1:0]   regs,
  output logic                    wr_stb,
  output logic [CFG_ADDR_W-1:0]   wr_addr,
  output logic [CFG_DATA_W-1:0]   wr_data,
  output logic                    addr_err,
  output logic [1:0]              dbg_state
);

  localparam int          WW        = $clog2(SYNC_STAGES + 1);
  localparam logic [8:0]  NUM_REGS9 = 9'(NUM_REGS);

  logic clk_s, mosi_s, nss_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk
    (.clk(clk), .rst(rst), .d(spi_clk),  .q(clk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi
    (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nss
    (.clk(clk), .rst(rst), .d(spi_nss),  .q(nss_s));

  // Edge detection. Right after reset nss_s still shows the synchronizer's
  // reset value (1), which would fake a falling edge if the pad is already
  // low. warm_cnt waits until the chain has flushed before nss_s is trusted.
  logic          clk_prev;
  logic          nss_prev;
  logic [WW-1:0] warm_cnt;
  logic          nss_valid;
  logic          nss_fall;
  logic          rise;

  assign nss_valid = (warm_cnt == WW'(SYNC_STAGES));
  assign nss_fall  = nss_valid & nss_prev & ~nss_s;
  assign rise      = clk_s & ~clk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev <= 1'b0;
      nss_prev <= 1'b0;
      warm_cnt <= '0;
    end else begin
      clk_prev <= clk_s;
      nss_prev <= nss_valid & nss_s;
      if (!nss_valid) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  rx_state_t             state;
  logic [2:0]            bit_cnt;
  logic [CFG_DATA_W-1:0] shift_q;
  logic [CFG_DATA_W-1:0] shift_nx;
  logic [CFG_ADDR_W-1:0] addr_q;
  logic [CFG_DATA_W-1:0] reg_bank [NUM_REGS];

  assign shift_nx  = {shift_q[CFG_DATA_W-2:0], mosi_s};
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift_q  <= '0;
      addr_q   <= '0;
      wr_stb   <= 1'b0;
      addr_err <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_bank[i] <= REG_RESET;
    end else begin
      wr_stb   <= 1'b0;
      addr_err <= 1'b0;
      // Deselect dominates everything, including a coincident rise.
      if (nss_s) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        shift_q <= '0;
      end else begin
        case (state)
          IDLE: if (nss_fall) state <= ADDR;
          ADDR: if (rise) begin
            shift_q <= shift_nx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr_q <= shift_nx;
              state  <= DATA;
            end
          end
          DATA: if (rise) begin
            shift_q <= shift_nx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_addr <= addr_q;
              wr_data <= shift_nx;
              if ({1'b0, addr_q} < NUM_REGS9) begin
                wr_stb <= 1'b1;
                for (int i = 0; i < NUM_REGS; i++)
                  if (addr_q == 8'(i)) reg_bank[i] <= shift_nx;
              end else begin
                addr_err <= 1'b1;
              end
`ifdef SPI_CFG_BURST_EN
              addr_q <= addr_q + 8'd1;  // wraps FF -> 00
`else
              state  <= HOLD;
`endif
            end
          end
          HOLD:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[8*g +: 8] = reg_bank[g];
  end

endmodule

// File: tb/tb_spi_cfg_rx.sv
module tb_spi_cfg_rx;

  localparam int NR = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            spi_clk  = 1'b0;
  logic            spi_mosi = 1'b0;
  logic            spi_nss  = 1'b1;
  logic [NR*8-1:0] regs;
  logic            wr_stb;
  logic [7:0]      wr_addr;
  logic [7:0]      wr_data;
  logic            addr_err;
  logic [1:0]      dbg_state;

  spi_cfg_rx #(.NUM_REGS(NR), .REG_RESET(8'h00), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_nss(spi_nss),
    .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .addr_err(addr_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int fails   = 0;
  logic [15:0] exp_q[$];      // expected {addr, data} per wr_stb
  logic [7:0]  model [NR];    // expected register contents
  int stb_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  // Pulse counters and write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (addr_err) err_cnt++;
    if (wr_stb) begin
      stb_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_stb", {wr_addr, wr_data}, 16'hxxxx);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_stb_addr_data", 128'({wr_addr, wr_data}), 128'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic spi_bit(input logic b);
    spi_mosi = b;
    repeat (3) @(negedge clk);
    spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic frame_start();
    @(negedge clk);
    spi_nss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    spi_nss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0, e0;
    logic [7:0] v;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    chk("rst_regs",     128'(regs),      128'(model_flat()));
    chk("rst_wr_stb",   128'(wr_stb),    128'd0);
    chk("rst_addr_err", 128'(addr_err),  128'd0);
    chk("rst_wr_addr",  128'(wr_addr),   128'd0);
    chk("rst_wr_data",  128'(wr_data),   128'd0);
    chk("rst_state",    128'(dbg_state), 128'd0);

    // 1) 0x03,0xA5 with exact write latency on the final bit
    s0 = stb_cnt; e0 = err_cnt;
    exp_q.push_back({8'h03, 8'hA5});
    frame_start();
    send_byte(8'h03);
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) spi_bit(v[i]);
    spi_mosi = v[0];
    repeat (3) @(negedge clk);
    spi_clk = 1'b1;
    @(posedge clk);              // edge k
    @(posedge clk); #1;          // edge k+1
    chk("lat_k1_stb",  128'(wr_stb),        128'd0);
    chk("lat_k1_reg3", 128'(regs[31:24]),   128'h00);
    @(posedge clk); #1;          // edge k+2
    model[3] = 8'hA5;
    chk("lat_k2_stb",  128'(wr_stb),        128'd1);
    chk("lat_k2_regs", 128'(regs),          128'(model_flat()));
    chk("lat_k2_addr", 128'(wr_addr),       128'h03);
    chk("lat_k2_data", 128'(wr_data),       128'hA5);
    @(posedge clk); #1;
    chk("lat_k3_stb",  128'(wr_stb),        128'd0);
    repeat (2) @(negedge clk);
    spi_clk = 1'b0;
    frame_end();
    chk("f1_stb_count", 128'(stb_cnt - s0), 128'd1);
    chk("f1_err_count", 128'(err_cnt - e0), 128'd0);

    // 2) Out-of-range address 0x20
    s0 = stb_cnt; e0 = err_cnt;
    frame_start();
    send_byte(8'h20);
    send_byte(8'h55);
    frame_end();
    chk("f2_err_count", 128'(err_cnt - e0), 128'd1);
    chk("f2_stb_count", 128'(stb_cnt - s0), 128'd0);
    chk("f2_regs",      128'(regs),         128'(model_flat()));
    chk("f2_wr_addr",   128'(wr_addr),      128'h20);
    chk("f2_wr_data",   128'(wr_data),      128'h55);

    // 3) Frame aborted after 12 bits, then 0x01,0x7E
    s0 = stb_cnt;
    frame_start();
    send_byte(8'h05);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    frame_end();
    chk("f3_abort_regs", 128'(regs), 128'(model_flat()));
    exp_q.push_back({8'h01, 8'h7E});
    frame_start();
    send_byte(8'h01);
    send_byte(8'h7E);
    frame_end();
    model[1] = 8'h7E;
    chk("f3_regs",      128'(regs),         128'(model_flat()));
    chk("f3_stb_count", 128'(stb_cnt - s0), 128'd1);

    // 4) Reset mid-frame with nss held low; remaining bits must not write
    s0 = stb_cnt; e0 = err_cnt;
    frame_start();
    send_byte(8'h02);
    spi_bit(1'b1);
    spi_bit(1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) spi_bit(1'b1);
    frame_end();
    chk("f4_stb_count", 128'(stb_cnt - s0), 128'd0);
    chk("f4_err_count", 128'(err_cnt - e0), 128'd0);
    chk("f4_regs",      128'(regs),         128'(model_flat()));
    chk("f4_wr_addr",   128'(wr_addr),      128'h00);

    // 5) Four bytes 0x0E,0x11,0x22,0x33 in one frame
    s0 = stb_cnt; e0 = err_cnt;
    exp_q.push_back({8'h0E, 8'h11});
    model[14] = 8'h11;
`ifdef SPI_CFG_BURST_EN
    exp_q.push_back({8'h0F, 8'h22});
    model[15] = 8'h22;
`endif
    frame_start();
    send_byte(8'h0E);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    frame_end();
    chk("f5_regs", 128'(regs), 128'(model_flat()));
`ifdef SPI_CFG_BURST_EN
    chk("f5_stb_count", 128'(stb_cnt - s0), 128'd2);
    chk("f5_err_count", 128'(err_cnt - e0), 128'd1);
    chk("f5_wr_addr",   128'(wr_addr),      128'h10);
`else
    chk("f5_stb_count", 128'(stb_cnt - s0), 128'd1);
    chk("f5_err_count", 128'(err_cnt - e0), 128'd0);
    chk("f5_wr_addr",   128'(wr_addr),      128'h0E);
`endif

    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
